// File: rtl/fm_cordic_pkg.sv
// Shared constants and types for the FM discriminator phase CORDIC.
// ATAN holds round(atan(2^-i) * 32768 / pi), so 0x8000 is -pi.
package fm_cordic_pkg;

  localparam int unsigned CORDIC_W = 34;

  localparam logic [15:0] PHASE_HALF_PI     = 16'h4000;
  localparam logic [15:0] PHASE_NEG_HALF_PI = 16'hC000;

  localparam logic [15:0] ATAN [16] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
  };

  typedef enum logic [1:0] {
    StIdle,
    StRotate,
    StOutput
  } state_e;

endpackage

// File: rtl/cordic_step.sv
// One combinational CORDIC vectoring micro-rotation: drives y towards zero
// and accumulates the applied rotation into z.
module cordic_step
  import fm_cordic_pkg::*;
(
  input  logic signed [CORDIC_W-1:0] x,
  input  logic signed [CORDIC_W-1:0] y,
  input  logic        [15:0]         z,
  input  logic        [3:0]          shift,
  input  logic        [15:0]         atan,
  output logic signed [CORDIC_W-1:0] x_next,
  output logic signed [CORDIC_W-1:0] y_next,
  output logic        [15:0]         z_next
);

  logic signed [CORDIC_W-1:0] x_shr;
  logic signed [CORDIC_W-1:0] y_shr;
  logic                       rot_pos;

  assign x_shr   = x >>> shift;
  assign y_shr   = y >>> shift;
  assign rot_pos = ~y[CORDIC_W-1];

  assign x_next = rot_pos ? x + y_shr : x - y_shr;
  assign y_next = rot_pos ? y - x_shr : y + x_shr;
  assign z_next = rot_pos ? z + atan  : z - atan;

endmodule

// File: rtl/fm_phase_cordic.sv
// Iterative CORDIC phase (and optional magnitude) of the FM discriminator product.
// Define FM_CORDIC_MAG_EN to place the magnitude in tdata[31:16].
module fm_phase_cordic
  import fm_cordic_pkg::*;
#(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned ITERATIONS             = 16
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  state_e                     state_q, state_d;
  logic [3:0]                 iter_q, iter_d;
  logic signed [CORDIC_W-1:0] x_q, x_d, y_q, y_d;
  logic [15:0]                z_q, z_d;
  logic                       zero_q, zero_d;
  logic                       last_q, last_d;
  logic                       tvalid_q, tvalid_d;
  logic                       tlast_q, tlast_d;
  logic [31:0]                tdata_q, tdata_d;

  logic signed [CORDIC_W-1:0] in_re, in_im;
  logic signed [CORDIC_W-1:0] x_step, y_step;
  logic [15:0]                z_step;
  logic [15:0]                phase;
  logic [31:0]                out_word;
  logic                       last_iter;
  logic                       unused_tstrb;

  assign unused_tstrb = ^s00_axis_tstrb;

  assign in_re = {{(CORDIC_W-32){s00_axis_tdata[31]}}, s00_axis_tdata[31:0]};
  assign in_im = {{(CORDIC_W-32){s00_axis_tdata[63]}}, s00_axis_tdata[63:32]};

  assign last_iter = (iter_q == 4'(ITERATIONS - 1));

  cordic_step u_step (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .shift  (iter_q),
    .atan   (ATAN[iter_q]),
    .x_next (x_step),
    .y_next (y_step),
    .z_next (z_step)
  );

  // Zero input has no defined angle; force a clean 0 rather than the CORDIC drift.
  assign phase = zero_q ? 16'h0000 : z_step;

`ifdef FM_CORDIC_MAG_EN
  logic [15:0] mag;

  always_comb begin
    mag = x_step[31:16];
    if (zero_q || x_step[CORDIC_W-1]) begin
      mag = 16'h0000;
    end else if (|x_step[CORDIC_W-2:32]) begin
      mag = 16'hFFFF;
    end
  end

  assign out_word = {mag, phase};
`else
  assign out_word = {{16{phase[15]}}, phase};
`endif

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    zero_d   = zero_q;
    last_d   = last_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    unique case (state_q)
      StIdle: begin
        if (s00_axis_tvalid && s00_axis_tready) begin
          zero_d  = (s00_axis_tdata[63:0] == 64'd0);
          last_d  = s00_axis_tlast;
          iter_d  = '0;
          state_d = StRotate;
          // Fold left half-plane inputs into x >= 0 so the iterations converge.
          if (!in_re[CORDIC_W-1]) begin
            x_d = in_re;
            y_d = in_im;
            z_d = 16'h0000;
          end else if (!in_im[CORDIC_W-1]) begin
            x_d = in_im;
            y_d = -in_re;
            z_d = PHASE_HALF_PI;
          end else begin
            x_d = -in_im;
            y_d = in_re;
            z_d = PHASE_NEG_HALF_PI;
          end
        end
      end
      StRotate: begin
        x_d    = x_step;
        y_d    = y_step;
        z_d    = z_step;
        iter_d = iter_q + 4'd1;
        if (last_iter) begin
          iter_d   = '0;
          tvalid_d = 1'b1;
          tlast_d  = last_q;
          tdata_d  = out_word;
          state_d  = StOutput;
        end
      end
      StOutput: begin
        if (m00_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q  <= StIdle;
      iter_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      zero_q   <= 1'b0;
      last_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      zero_q   <= zero_d;
      last_q   <= last_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end

  // Gated by reset so the upstream sees not-ready while the block is held in reset.
  assign s00_axis_tready = (state_q == StIdle) && s00_axis_aresetn;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = 4'hF;

endmodule
